// File: rtl/stage5_fetch_pkg.sv
// Shared types and constants for the fetch stage: word type, reset PC,
// the NOP used for synthetic fault instructions, and the fetch FSM states.
package stage5_fetch_pkg;

    typedef logic [31:0] word_t;

    localparam word_t RESET_PC_DEFAULT = 32'h8000_0000;
    localparam word_t NOP_INSN         = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/stage5_fetch_hold_buffer.sv
// One-entry buffer for an instruction that came back while decode was stalled.
// Clear has priority over capture.
module stage5_fetch_hold_buffer
    import stage5_fetch_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  capture,
    input  logic  clear,
    input  word_t cap_pc,
    input  word_t cap_instr,
    input  logic  cap_fault,
    input  logic  cap_mal,
    output logic  valid,
    output word_t pc,
    output word_t instr,
    output logic  fault,
    output logic  mal
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
            fault <= 1'b0;
            mal   <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            pc    <= cap_pc;
            instr <= cap_instr;
            fault <= cap_fault;
            mal   <= cap_mal;
        end
    end

endmodule

// File: rtl/stage5_fetch_stage.sv
// Instruction fetch stage: PC register, imem request, next-PC selection,
// F/D pipeline latch and a one-entry hold buffer for stalled responses.
//
//   state | meaning
//   BOOT  | one idle cycle after reset, no request
//   FETCH | issuing requests (or synthesising misaligned faults)
//   HOLD  | a response is parked in the hold buffer, no request
module stage5_fetch_stage
    import stage5_fetch_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pc_en,
    input  logic        npc_sel,
    input  logic [31:0] branch_target,
    input  logic        insert_priv_pc,
    input  logic [31:0] priv_pc,
    input  logic        suppress_iren,
    input  logic        if_dc_flush,
    input  logic        if_dc_stall,
    output logic        iren,
    output logic [31:0] iaddr,
    input  logic        i_mem_busy,
    input  logic [31:0] i_rdata,
    input  logic        i_fault,
    output logic        fd_valid,
    output logic [31:0] fd_pc,
    output logic [31:0] fd_instr,
    output logic        fd_fault_insn,
    output logic        fd_mal_insn
);

    fetch_state_e state;
    word_t        pc;
    logic         misaligned;
    logic         rsp_valid;
    word_t        rsp_instr;
    logic         rsp_fault;
    logic         capture;
    logic         clear_hold;
    logic         h_valid;
    word_t        h_pc;
    word_t        h_instr;
    logic         h_fault;
    logic         h_mal;

    // A misaligned PC never reaches the bus; it completes at once as a NOP.
    assign misaligned = (pc[1:0] != 2'b00);
    assign iren       = (state == FETCH) && !suppress_iren && !misaligned;
    assign iaddr      = pc;
    assign rsp_valid  = (state == FETCH) && !suppress_iren && (misaligned || !i_mem_busy);
    assign rsp_instr  = misaligned ? NOP_INSN : i_rdata;
    assign rsp_fault  = !misaligned && i_fault;
    assign capture    = rsp_valid && if_dc_stall && !if_dc_flush;
    assign clear_hold = (state == HOLD) && (if_dc_flush || !if_dc_stall);

    stage5_fetch_hold_buffer u_hold (
        .CLK       (CLK),
        .RST       (RST),
        .capture   (capture),
        .clear     (clear_hold),
        .cap_pc    (pc),
        .cap_instr (rsp_instr),
        .cap_fault (rsp_fault),
        .cap_mal   (misaligned),
        .valid     (h_valid),
        .pc        (h_pc),
        .instr     (h_instr),
        .fault     (h_fault),
        .mal       (h_mal)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc <= RESET_PC;
        end else if (pc_en) begin
            if (insert_priv_pc)
                pc <= priv_pc;
            else if (npc_sel)
                pc <= branch_target;
            else
                pc <= pc + 32'd4;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= BOOT;
        end else begin
            case (state)
                BOOT:    state <= FETCH;
                FETCH:   if (capture) state <= HOLD;
                HOLD:    if (if_dc_flush || !if_dc_stall) state <= FETCH;
                default: state <= BOOT;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fd_valid      <= 1'b0;
            fd_pc         <= '0;
            fd_instr      <= '0;
            fd_fault_insn <= 1'b0;
            fd_mal_insn   <= 1'b0;
        end else if (if_dc_flush) begin
            fd_valid <= 1'b0;
        end else if (!if_dc_stall) begin
            if (state == HOLD) begin
                fd_valid      <= h_valid;
                fd_pc         <= h_pc;
                fd_instr      <= h_instr;
                fd_fault_insn <= h_fault;
                fd_mal_insn   <= h_mal;
            end else if (rsp_valid) begin
                fd_valid      <= 1'b1;
                fd_pc         <= pc;
                fd_instr      <= rsp_instr;
                fd_fault_insn <= rsp_fault;
                fd_mal_insn   <= misaligned;
            end else begin
                fd_valid <= 1'b0;
            end
        end
    end

endmodule
